rv32e_wb_arbiter: RTL and testbench



---
 rtl/rv32e_pkg.sv | 17 +
 rtl/rv32e_scoreboard.sv | 36 +++
 rtl/rv32e_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_rv32e_wb_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32e_pkg.sv
// Shared RV32E writeback definitions: register-file geometry, arbiter state
// encoding and the writeback request payload.
package rv32e_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned NUM_REGS   = 16;
  localparam int unsigned XLEN       = 32;

  localparam logic ARB_B_PRI   = 1'b0;
  localparam logic ARB_A_FORCE = 1'b1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/rv32e_scoreboard.sv
// Pending-write scoreboard for long-latency results; decode reads the busy
// flags to stall on registers whose B write has not landed yet.
module rv32e_scoreboard
  import rv32e_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  // Set is applied after clear so a re-issue in the clearing cycle stays busy
  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_rd] = 1'b0;
    if (set_en && (set_rd != '0)) pending_nxt[set_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign rs1_busy = pending[rs1_addr] && (rs1_addr != '0);
  assign rs2_busy = pending[rs2_addr] && (rs2_addr != '0);

endmodule

// File: rtl/rv32e_wb_arbiter.sv
// Two-requester writeback arbiter for the RV32E register-file write port with
// starvation guard and pending-write scoreboard. Optional forwarding outputs
// are enabled by defining RV32E_WB_FWD_EN.
module rv32e_wb_arbiter
  import rv32e_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned CNT_W        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [XLEN-1:0]       a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [XLEN-1:0]       b_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]       rd_data,
  output logic                  rd_we
`ifdef RV32E_WB_FWD_EN
  ,
  output logic                  rs1_fwd,
  output logic                  rs2_fwd,
  output logic [XLEN-1:0]       fwd_data
`endif
);

  logic             state;
  logic             state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;
  logic             a_xfer;
  logic             b_xfer;
  wb_req_t          win;

  assign a_xfer = a_valid && a_ready;
  assign b_xfer = b_valid && b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_B_PRI;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Counter tracks consecutive A losses; reaching the limit forces A next cycle
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = (a_valid && !a_ready) ? starve_cnt + CNT_W'(1) : '0;
    case (state)
      ARB_B_PRI: begin
        if (starve_cnt_nxt == CNT_W'(STARVE_LIMIT)) state_nxt = ARB_A_FORCE;
      end
      ARB_A_FORCE: begin
        if (a_xfer || b_xfer || (!a_valid && !b_valid)) state_nxt = ARB_B_PRI;
      end
      default: state_nxt = ARB_B_PRI;
    endcase
  end

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state)
      ARB_B_PRI: begin
        b_ready = b_valid;
        a_ready = a_valid && !b_valid;
      end
      ARB_A_FORCE: begin
        a_ready = a_valid;
        b_ready = b_valid && !a_valid;
      end
      default: ;
    endcase
  end

  assign win = b_xfer ? wb_req_t'{rd: b_rd, data: b_data}
                      : wb_req_t'{rd: a_rd, data: a_data};

  // Writes to x0 are accepted but never reach the register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_we   <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else if (a_xfer || b_xfer) begin
      rd_we   <= (win.rd != '0);
      rd_addr <= win.rd;
      rd_data <= win.data;
    end else begin
      rd_we   <= 1'b0;
    end
  end

  rv32e_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue_valid),
    .set_rd   (issue_rd),
    .clr_en   (b_xfer),
    .clr_rd   (b_rd),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

`ifdef RV32E_WB_FWD_EN
  assign rs1_fwd  = rd_we && (rd_addr == rs1_addr);
  assign rs2_fwd  = rd_we && (rd_addr == rs2_addr);
  assign fwd_data = rd_data;
`endif

endmodule

// File: tb/tb_rv32e_wb_arbiter.sv
// Self-checking bench for rv32e_wb_arbiter: per-cycle vector table with a
// queue of expected register-file writes, plus a reset-during-write sequence.
module tb_rv32e_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, issue_valid;
  logic        a_ready, b_ready, rs1_busy, rs2_busy, rd_we;
  logic [3:0]  a_rd, b_rd, issue_rd, rs1_addr, rs2_addr, rd_addr;
  logic [31:0] a_data, b_data, rd_data;
`ifdef RV32E_WB_FWD_EN
  logic        rs1_fwd, rs2_fwd;
  logic [31:0] fwd_data;
`endif

  always #5 clk = ~clk;

  rv32e_wb_arbiter #(.STARVE_LIMIT(3), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_rd        (a_rd),
    .a_data      (a_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_rd        (b_rd),
    .b_data      (b_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_we       (rd_we)
`ifdef RV32E_WB_FWD_EN
    ,
    .rs1_fwd     (rs1_fwd),
    .rs2_fwd     (rs2_fwd),
    .fwd_data    (fwd_data)
`endif
  );

  typedef struct {
    logic        av;
    logic [3:0]  ard;
    logic [31:0] ad;
    logic        bv;
    logic [3:0]  brd;
    logic [31:0] bd;
    logic        iv;
    logic [3:0]  ird;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic        ea;
    logic        eb;
    logic        e1;
    logic        e2;
  } vec_t;

  typedef struct {
    logic        xfer;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;

  function automatic vec_t mk(input logic av, input logic [3:0] ard, input logic [31:0] ad,
                              input logic bv, input logic [3:0] brd, input logic [31:0] bd,
                              input logic iv, input logic [3:0] ird,
                              input logic [3:0] r1, input logic [3:0] r2,
                              input logic ea, input logic eb, input logic e1, input logic e2);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.bv = bv; v.brd = brd; v.bd = bd;
    v.iv = iv; v.ird = ird; v.r1 = r1; v.r2 = r2;
    v.ea = ea; v.eb = eb; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, step_no, act, req);
    end
  endtask

  // Compare registered write port against the oldest expected write
  task automatic pop_check();
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("rd_we", 32'(rd_we), 32'(e.we));
      if (e.xfer) begin
        chk("rd_addr", 32'(rd_addr), 32'(e.addr));
        chk("rd_data", rd_data, e.data);
      end
`ifdef RV32E_WB_FWD_EN
      chk("rs1_fwd", 32'(rs1_fwd), 32'(e.we && (e.addr == rs1_addr)));
      chk("rs2_fwd", 32'(rs2_fwd), 32'(e.we && (e.addr == rs2_addr)));
      if (e.we) chk("fwd_data", fwd_data, e.data);
`endif
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    pop_check();
    step_no++;
    a_valid = v.av; a_rd = v.ard; a_data = v.ad;
    b_valid = v.bv; b_rd = v.brd; b_data = v.bd;
    issue_valid = v.iv; issue_rd = v.ird;
    rs1_addr = v.r1; rs2_addr = v.r2;
    #3;
    chk("a_ready", 32'(a_ready), 32'(v.ea));
    chk("b_ready", 32'(b_ready), 32'(v.eb));
    chk("rs1_busy", 32'(rs1_busy), 32'(v.e1));
    chk("rs2_busy", 32'(rs2_busy), 32'(v.e2));
    e.xfer = v.ea || v.eb;
    e.we = 1'b0; e.addr = '0; e.data = '0;
    if (v.eb) begin
      e.addr = v.brd; e.data = v.bd; e.we = (v.brd != 4'd0);
    end else if (v.ea) begin
      e.addr = v.ard; e.data = v.ad; e.we = (v.ard != 4'd0);
    end
    expq.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    rs1_addr = '0; rs2_addr = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    rs1_addr = 4'd3; rs2_addr = 4'd7;
    #12;
    chk("reset rd_we", 32'(rd_we), 32'd0);
    chk("reset rd_addr", 32'(rd_addr), 32'd0);
    chk("reset rd_data", rd_data, 32'd0);
    chk("reset a_ready", 32'(a_ready), 32'd0);
    chk("reset b_ready", 32'(b_ready), 32'd0);
    chk("reset rs1_busy", 32'(rs1_busy), 32'd0);
    chk("reset rs2_busy", 32'(rs2_busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    //                av ard  ad            bv brd  bd            iv ird  r1  r2  ea eb e1 e2
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  0,  0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h1111,     0, 0,  32'h0,        0, 0,  0,  0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 2,  32'h1234,     0, 0,  0,  2,  0, 1, 0, 0));
    // collision, then the loser A retries alone
    vecs.push_back(mk(1, 3, 32'hAAAA,     1, 4,  32'hBBBB,     0, 0,  0,  0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 3, 32'hAAAA,     0, 0,  32'h0,        0, 0,  0,  0,  1, 0, 0, 0));
    // x0 write and x0 issue
    vecs.push_back(mk(1, 0, 32'hFFFF,     0, 0,  32'h0,        1, 0,  0,  0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  0,  0,  0, 0, 0, 0));
    // starvation: three losses, forced A grant, then B resumes
    vecs.push_back(mk(1, 7, 32'h7777,     1, 10, 32'hB0A,      0, 0,  0,  0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 7, 32'h7777,     1, 11, 32'hB0B,      0, 0,  0,  0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 7, 32'h7777,     1, 12, 32'hB0C,      0, 0,  0,  0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 7, 32'h7777,     1, 13, 32'hB0D,      0, 0,  0,  0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 13, 32'hB0D,      0, 0,  0,  0,  0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 14, 32'hB0E,      0, 0,  0,  0,  0, 1, 0, 0));
    // second starvation run confirms the counter restarted from zero
    vecs.push_back(mk(1, 8, 32'h8888,     1, 10, 32'hC10,      0, 0,  0,  0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 8, 32'h8888,     1, 11, 32'hC11,      0, 0,  0,  0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 8, 32'h8888,     1, 12, 32'hC12,      0, 0,  0,  0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 8, 32'h8888,     1, 13, 32'hC13,      0, 0,  0,  0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 13, 32'hC13,      0, 0,  0,  0,  0, 1, 0, 0));
    // scoreboard set/clear, A write ignored, set-wins-over-clear
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        1, 9,  9,  0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        1, 6,  9,  6,  0, 0, 1, 0));
    vecs.push_back(mk(1, 9, 32'h5,        0, 0,  32'h0,        0, 0,  9,  6,  1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 9,  32'h99,       0, 0,  9,  6,  0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  9,  6,  0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 9,  32'h9A,       1, 9,  9,  6,  0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  9,  6,  0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 6,  32'h66,       0, 0,  9,  6,  0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  9,  6,  0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 9,  32'h9B,       0, 0,  9,  6,  0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  9,  6,  0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);
    pop_check();

    // reset arriving right after a write is registered
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 4'd12;
    @(posedge clk); #1;
    idle_inputs();
    a_valid = 1'b1; a_rd = 4'd5; a_data = 32'h11; rs1_addr = 4'd12;
    #3;
    chk("mid a_ready", 32'(a_ready), 32'd1);
    chk("mid rs1_busy pre", 32'(rs1_busy), 32'd1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    chk("mid rd_we pre", 32'(rd_we), 32'd1);
    chk("mid rd_addr pre", 32'(rd_addr), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("mid rd_we rst", 32'(rd_we), 32'd0);
    chk("mid rd_addr rst", 32'(rd_addr), 32'd0);
    chk("mid rd_data rst", rd_data, 32'd0);
    chk("mid rs1_busy rst", 32'(rs1_busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post rd_we", 32'(rd_we), 32'd0);
    chk("post rs1_busy", 32'(rs1_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
